// File: rtl/booth_mult_arbiter_if.sv
// booth_mult_arbiter_if: handshake bundle between two requesters, a result consumer and the shared Booth multiplier
interface booth_mult_arbiter_if #(
    parameter int WIDTH = 8
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic [WIDTH-1:0]     req0_a;
    logic [WIDTH-1:0]     req0_b;
    logic                 req1_valid;
    logic                 req1_ready;
    logic [WIDTH-1:0]     req1_a;
    logic [WIDTH-1:0]     req1_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res_product;
    logic                 res_id;
    logic                 busy;

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output res_ready,
        input  req0_ready, req1_ready,
        input  res_valid, res_product, res_id, busy
    );

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  res_ready,
        output req0_ready, req1_ready,
        output res_valid, res_product, res_id, busy
    );
endinterface

// File: rtl/booth_mult_arbiter.sv
// booth_mult_arbiter: round-robin two-port front end feeding one sequential radix-2 Booth signed multiplier
module booth_mult_arbiter #(
    parameter int WIDTH = 8
) (
    input logic clk,
    input logic rst,
    booth_mult_arbiter_if.slave bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t             state;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               id;
    logic               last_grant;
    logic               e;
    logic [2*WIDTH:0]   acc;
    logic [CW-1:0]      cnt;
    logic               res_valid;
    logic [2*WIDTH-1:0] res_product;
    logic               res_id;

    logic               grant;
    logic               accept;
    logic [1:0]         pair;
    logic [WIDTH:0]     upper;
    logic [WIDTH:0]     b_ext;
    logic [WIDTH:0]     upper_next;
    logic [2*WIDTH:0]   acc_next;
    logic               last_step;

    // Grant the lone valid requester, or on a tie the one not served last
    always_comb begin
        grant  = (bus.req0_valid && bus.req1_valid) ? ~last_grant : bus.req1_valid;
        accept = (state == IDLE) && !rst && (bus.req0_valid || bus.req1_valid);
    end

    assign bus.req0_ready  = accept && !grant;
    assign bus.req1_ready  = accept && grant;
    assign bus.res_valid   = res_valid;
    assign bus.res_product = res_product;
    assign bus.res_id      = res_id;
    assign bus.busy        = (state != IDLE);

    // One Booth step: add/subtract B in the WIDTH+1-bit upper half, then arithmetic shift right
    always_comb begin
        pair       = {a[cnt], e};
        upper      = acc[2*WIDTH:WIDTH];
        b_ext      = {b[WIDTH-1], b};
        upper_next = (pair == 2'b10) ? upper - b_ext :
                     (pair == 2'b01) ? upper + b_ext : upper;
        acc_next   = $signed({upper_next, acc[WIDTH-1:0]}) >>> 1;
        last_step  = (cnt == CW'(WIDTH - 1));
    end

    // Control FSM: accept in IDLE, WIDTH Booth steps in RUN, hold the result in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            a           <= '0;
            b           <= '0;
            id          <= 1'b0;
            last_grant  <= 1'b1;
            e           <= 1'b0;
            acc         <= '0;
            cnt         <= '0;
            res_valid   <= 1'b0;
            res_product <= '0;
            res_id      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        a          <= grant ? bus.req1_a : bus.req0_a;
                        b          <= grant ? bus.req1_b : bus.req0_b;
                        id         <= grant;
                        last_grant <= grant;
                        acc        <= '0;
                        e          <= 1'b0;
                        cnt        <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    acc <= acc_next;
                    e   <= a[cnt];
                    cnt <= cnt + 1'b1;
                    if (last_step) begin
                        res_product <= acc_next[2*WIDTH-1:0];
                        res_id      <= id;
                        res_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        res_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_booth_mult_arbiter.sv
// tb_booth_mult_arbiter: directed vectors, arbitration/stall/reset sequences and a randomized scoreboard run
module tb_booth_mult_arbiter;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    booth_mult_arbiter_if #(.WIDTH(8)) bus ();

    booth_mult_arbiter #(.WIDTH(8)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          id;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] prod;
    } vec_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
    } op_t;

    vec_t vecs[5];
    op_t  q0[$];
    op_t  q1[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic run_op(input bit id, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] p, output bit rid, output int lat, output bit rdy);
        if (id) begin
            bus.req1_valid = 1'b1;
            bus.req1_a = a;
            bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1;
            bus.req0_a = a;
            bus.req0_b = b;
        end
        @(negedge clk);
        rdy = id ? bus.req1_ready : bus.req0_ready;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = 0;
        while (lat < 30 && !bus.res_valid) begin
            @(posedge clk); #1;
            lat++;
        end
        p = bus.res_product;
        rid = bus.res_id;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] p;
        bit          rid;
        bit          rdy;
        bit          stable;
        bit          saw;
        int          lat;
        int          w;
        int          prev;
        int          results;
        int          guard;
        bit          outst;
        bit          mlast;
        bit          er0;
        bit          er1;
        bit          hs0;
        bit          hs1;
        op_t         o;

        vecs[0] = '{1'b0, 8'd3,  8'd5,  16'd15};
        vecs[1] = '{1'b1, 8'h80, 8'h80, 16'h4000};
        vecs[2] = '{1'b1, 8'h80, 8'h7F, 16'hC080};
        vecs[3] = '{1'b1, 8'hFF, 8'hFF, 16'h0001};
        vecs[4] = '{1'b1, 8'h00, 8'hB3, 16'h0000};

        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        bus.req0_a = 8'd1;
        bus.req0_b = 8'd1;
        bus.req1_a = 8'd1;
        bus.req1_b = 8'd1;
        bus.res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req0_ready", bus.req0_ready, 0);
        chk("reset_req1_ready", bus.req1_ready, 0);
        chk("reset_res_valid", bus.res_valid, 0);
        chk("reset_busy", bus.busy, 0);
        chk("reset_res_product", bus.res_product, 0);
        chk("reset_res_id", bus.res_id, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 5; i++) begin
            run_op(vecs[i].id, vecs[i].a, vecs[i].b, p, rid, lat, rdy);
            chk("tbl_ready", rdy, 1);
            chk("tbl_latency", lat, 8);
            chk("tbl_product", longint'($signed(p)), longint'($signed(vecs[i].prod)));
            chk("tbl_id", rid, vecs[i].id);
        end

        bus.req0_a = 8'd5;
        bus.req0_b = 8'hFA;
        bus.req1_a = 8'hF9;
        bus.req1_b = 8'd9;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            w = 0;
            while (!bus.res_valid && w < 40) begin
                @(posedge clk); #1;
                w++;
            end
            chk("tie_res_valid", bus.res_valid, 1);
            chk("tie_id", bus.res_id, i % 2);
            chk("tie_product", longint'($signed(bus.res_product)), (i % 2) ? -63 : -30);
            if (i > 0) chk("tie_spacing", cyc - prev, 10);
            prev = cyc;
            @(posedge clk); #1;
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;

        bus.res_ready = 1'b0;
        bus.req0_a = 8'd3;
        bus.req0_b = 8'hFC;
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        w = 0;
        while (!bus.res_valid && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("stall_product", longint'($signed(bus.res_product)), -12);
        chk("stall_id", bus.res_id, 0);
        stable = 1'b1;
        repeat (20) begin
            @(posedge clk); #1;
            if (!(bus.res_valid && bus.res_product == 16'hFFF4 && !bus.res_id &&
                  !bus.req0_ready && !bus.req1_ready && bus.busy)) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        bus.res_ready = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(posedge clk); #1;
        chk("stall_release_busy", bus.busy, 0);
        chk("stall_release_valid", bus.res_valid, 0);

        bus.req0_a = 8'd7;
        bus.req0_b = 8'd9;
        bus.req0_valid = 1'b1;
        @(posedge clk); #1;
        bus.req0_valid = 1'b0;
        chk("rst_op_started", bus.busy, 1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        bus.req0_a = 8'd2;
        bus.req0_b = 8'hFD;
        @(negedge clk);
        chk("rst_cycle_ready", bus.req0_ready, 0);
        @(posedge clk); #1;
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_res_product", bus.res_product, 0);
        chk("rst_res_id", bus.res_id, 0);
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        saw = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (bus.res_valid || bus.busy) saw = 1'b1;
        end
        chk("rst_no_result", saw, 0);
        run_op(1'b0, 8'd2, 8'hFD, p, rid, lat, rdy);
        chk("rst_new_ready", rdy, 1);
        chk("rst_new_latency", lat, 8);
        chk("rst_new_product", longint'($signed(p)), -6);
        chk("rst_new_id", rid, 0);

        results = 0;
        guard = 0;
        outst = 1'b0;
        mlast = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        while (results < 3000 && guard < 70000) begin
            @(negedge clk);
            guard++;
            er0 = !outst && bus.req0_valid && (!bus.req1_valid || mlast);
            er1 = !outst && bus.req1_valid && (!bus.req0_valid || !mlast);
            chk("rand_ready0", bus.req0_ready, er0);
            chk("rand_ready1", bus.req1_ready, er1);
            hs0 = bus.req0_valid && bus.req0_ready;
            hs1 = bus.req1_valid && bus.req1_ready;
            if (bus.res_valid && bus.res_ready) begin
                chk("rand_in_flight", outst, 1);
                if ((bus.res_id ? q1.size() : q0.size()) == 0) begin
                    chk("rand_duplicate", 1, 0);
                end else begin
                    o = bus.res_id ? q1.pop_front() : q0.pop_front();
                    chk("rand_product", longint'($signed(bus.res_product)),
                        longint'($signed(o.a)) * longint'($signed(o.b)));
                end
                results++;
                outst = 1'b0;
            end
            if (hs0) begin
                q0.push_back('{bus.req0_a, bus.req0_b});
                outst = 1'b1;
                mlast = 1'b0;
            end
            if (hs1) begin
                q1.push_back('{bus.req1_a, bus.req1_b});
                outst = 1'b1;
                mlast = 1'b1;
            end
            @(posedge clk); #1;
            if (hs0 || !bus.req0_valid) begin
                bus.req0_valid = ($urandom % 3) != 0;
                bus.req0_a = 8'($urandom);
                bus.req0_b = 8'($urandom);
            end
            if (hs1 || !bus.req1_valid) begin
                bus.req1_valid = ($urandom % 3) != 0;
                bus.req1_a = 8'($urandom);
                bus.req1_b = 8'($urandom);
            end
            bus.res_ready = ($urandom % 4) != 0;
        end
        chk("rand_result_count", results, 3000);
        chk("rand_leftover", q0.size() + q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
